// File: rtl/range_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : range_stream_if
//  Description : go/finish sample-stream link between a transmitter and the
//                range-finder receiver.
//                  go        first word of a burst
//                  finish    last word of a burst
//                  data_out  sample word
//                  range_in  receiver range, valid in the finish cycle
//                  error_in  receiver error flag
//                master = transmitter side, slave = receiver side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface range_stream_if #(
    parameter int WIDTH = 2
);
    logic             go;
    logic             finish;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] range_in;
    logic             error_in;

    modport master (
        output go,
        output finish,
        output data_out,
        input  range_in,
        input  error_in
    );

    modport slave (
        input  go,
        input  finish,
        input  data_out,
        output range_in,
        output error_in
    );
endinterface
`default_nettype wire

// File: rtl/range_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : range_stream_tx
//  Description : Transmit side of the go/finish sample-stream protocol.
//                Buffers up to DEPTH samples, replays them back-to-back on
//                start (go on the first word, finish on the last), captures
//                the receiver's range in the finish cycle together with any
//                error seen after the go cycle, and reports both as a result.
//  Ports       : clock, reset        rising-edge clock, async active-high reset
//                wr_en, wr_data      sample write port (accepted only when idle)
//                count, full         buffer occupancy
//                start, busy         burst request / burst or result in progress
//                stream              go/finish/data_out out, range_in/error_in in
//                result_valid        one-cycle pulse when result fields update
//                result, result_error captured range and accumulated error
//  Revision    : 1.0 - initial release
// ============================================================================
module range_stream_tx #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    input  logic                       start,
    output logic                       busy,
    range_stream_if.master             stream,
    output logic                       result_valid,
    output logic [WIDTH-1:0]           result,
    output logic                       result_error
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The FSM state describes what is currently visible on the stream outputs:
    // SEND = a buffered word, REPEAT = the duplicated single word (N==1),
    // RESULT = the result_valid cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_REPEAT = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // r_armed marks the cycle between sampling start and driving word 0; it
    // provides the register stage that puts go one cycle after start.
    logic               r_armed;
    logic [c_CNT_W-1:0] r_n;       // burst length latched at start
    logic [c_CNT_W-1:0] r_sent;    // words already placed on the stream
    logic               r_go;
    logic               r_finish;
    logic [WIDTH-1:0]   r_data;
    logic               r_err_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_result_error;

    logic w_full;
    logic w_start_ok;
    logic w_launch;
    logic w_pop;
    logic w_push;
    logic w_repeat;
    logic w_capture;

    assign w_full = (r_count == c_CNT_W'(DEPTH));

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_launch     = 1'b0;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_repeat     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed) begin
                    w_launch     = 1'b1;
                    w_pop        = 1'b1;
                    w_state_next = ST_SEND;
                end else begin
                    w_start_ok = start && (r_count != '0);
                    // A write coinciding with an accepted start is dropped so
                    // the latched burst length matches the buffer contents.
                    w_push     = wr_en && !w_full && !w_start_ok;
                end
            end
            ST_SEND: begin
                if (r_finish) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESULT;
                end else if (r_sent == r_n) begin
                    // Only reachable with N==1: the single word was go-only.
                    w_repeat     = 1'b1;
                    w_state_next = ST_REPEAT;
                end else begin
                    w_pop = 1'b1;
                end
            end
            ST_REPEAT: begin
                w_capture    = 1'b1;
                w_state_next = ST_RESULT;
            end
            ST_RESULT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer storage (no reset needed: occupancy is tracked separately)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Buffer pointers, burst sequencing and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_armed        <= 1'b0;
            r_n            <= '0;
            r_sent         <= '0;
            r_go           <= 1'b0;
            r_finish       <= 1'b0;
            r_data         <= '0;
            r_err_acc      <= 1'b0;
            r_result       <= '0;
            r_result_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
                r_count  <= r_count + c_CNT_W'(1);
            end else if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
                r_count  <= r_count - c_CNT_W'(1);
            end

            if (w_start_ok) begin
                r_armed <= 1'b1;
                r_n     <= r_count;
            end

            if (w_launch) begin
                r_armed  <= 1'b0;
                r_sent   <= c_CNT_W'(1);
                r_go     <= 1'b1;
                r_finish <= 1'b0;
                r_data   <= r_mem[r_rd_ptr];
            end else if (w_pop) begin
                r_sent   <= r_sent + c_CNT_W'(1);
                r_go     <= 1'b0;
                r_finish <= (r_sent == r_n - c_CNT_W'(1));
                r_data   <= r_mem[r_rd_ptr];
            end else if (w_repeat) begin
                // Re-send the held word, now marked as the last one.
                r_go     <= 1'b0;
                r_finish <= 1'b1;
            end else if (w_capture) begin
                r_go     <= 1'b0;
                r_finish <= 1'b0;
                r_data   <= '0;
            end

            // Error is collected over every burst cycle except the go cycle,
            // where a receiver leaving its error state may still flag it.
            if (w_launch) begin
                r_err_acc <= 1'b0;
            end else if ((r_state == ST_SEND || r_state == ST_REPEAT) && !r_go) begin
                r_err_acc <= r_err_acc | stream.error_in;
            end

            // The capture cycle is always the finish cycle, never a go cycle.
            if (w_capture) begin
                r_result       <= stream.range_in;
                r_result_error <= r_err_acc | stream.error_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count           = r_count;
    assign full            = w_full;
    assign busy            = (r_state != ST_IDLE) || r_armed;
    assign stream.go       = r_go;
    assign stream.finish   = r_finish;
    assign stream.data_out = r_data;
    assign result_valid    = (r_state == ST_RESULT);
    assign result          = r_result;
    assign result_error    = r_result_error;

endmodule
`default_nettype wire
